// File: rtl/fifo_1r1w_ctrl_if.sv
// Push/pop handshake and RAM port bundle for fifo_1r1w_ctrl.
// The slave modport is the controller's view, and the master modport is the environment's view.
interface fifo_1r1w_ctrl_if #(
  parameter int DBITS = 32,
  parameter int ABITS = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [DBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_data;
  logic [ABITS+1:0] count;
  logic [ABITS-1:0] ram_waddr;
  logic [DBITS-1:0] ram_wr;
  logic             ram_we;
  logic [ABITS-1:0] ram_raddr;
  logic             ram_re;
  logic [DBITS-1:0] ram_rd;

  modport slave (
    input  in_valid, in_data, out_ready, ram_rd,
    output in_ready, out_valid, out_data, count,
           ram_waddr, ram_wr, ram_we, ram_raddr, ram_re
  );

  modport master (
    output in_valid, in_data, out_ready, ram_rd,
    input  in_ready, out_valid, out_data, count,
           ram_waddr, ram_wr, ram_we, ram_raddr, ram_re
  );
endinterface

// File: rtl/fifo_1r1w_ctrl.sv
// FIFO controller over an external 1R1W RAM with registered read.
// A 2-entry head/skid stage hides the read latency, so the FIFO sustains 1 push and 1 pop per cycle.
module fifo_1r1w_ctrl #(
  parameter int DBITS = 32,
  parameter int ABITS = 7
) (
  input logic              clk,
  input logic              rst,
  fifo_1r1w_ctrl_if.slave  bus
);
  localparam logic [ABITS:0] FULL = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] wptr, rptr;
  logic [ABITS:0]   ram_cnt;
  logic             rd_pend;
  logic [1:0]       os_cnt, os_left;
  logic [2:0]       os_sum;
  logic [DBITS-1:0] head, skid, head_nxt, skid_nxt;
  logic             pop;

  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.in_ready = rst & (ram_cnt != FULL);
  assign bus.ram_we   = bus.in_valid & bus.in_ready;

  // Output-stage occupancy after this cycle's pop and return. A read is issued only if its data will have a slot.
  assign os_left     = os_cnt - {1'b0, pop};
  assign os_sum      = {1'b0, os_left} + {2'b0, rd_pend};
  assign bus.ram_re  = rst & (ram_cnt != '0) & (os_sum < 3'd2);

  assign bus.ram_waddr = wptr;
  assign bus.ram_wr    = bus.in_data;
  assign bus.ram_raddr = rptr;
  assign bus.out_valid = (os_cnt != 2'd0);
  assign bus.out_data  = head;
  assign bus.count     = {1'b0, ram_cnt} + (ABITS+2)'(rd_pend) + (ABITS+2)'(os_cnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      os_cnt  <= '0;
    end else begin
      if (bus.ram_we) wptr <= wptr + 1'b1;
      if (bus.ram_re) rptr <= rptr + 1'b1;
      ram_cnt <= ram_cnt + (ABITS+1)'(bus.ram_we) - (ABITS+1)'(bus.ram_re);
      rd_pend <= bus.ram_re;
      os_cnt  <= os_sum[1:0];
    end
  end

  // Pop shifts skid into head first, and returning data then lands in the first free slot.
  always_comb begin
    head_nxt = pop ? skid : head;
    skid_nxt = skid;
    if (rd_pend) begin
      if (os_left == 2'd0) head_nxt = bus.ram_rd;
      else                 skid_nxt = bus.ram_rd;
    end
  end

  always_ff @(posedge clk) begin
    head <= head_nxt;
    skid <= skid_nxt;
  end

  assert property (@(posedge clk) disable iff (!rst) os_sum <= 3'd2);
endmodule

// File: tb/tb_fifo_1r1w_ctrl.sv
// Directed and scoreboarded checks of fifo_1r1w_ctrl against a behavioural 1R1W RAM.
module tb_fifo_1r1w_ctrl;
  localparam int DBITS = 32;
  localparam int ABITS = 3;
  localparam int DEPTH = 8;

  logic clk, rst;
  int   tests = 0;
  int   fails = 0;

  fifo_1r1w_ctrl_if #(.DBITS(DBITS), .ABITS(ABITS)) bus();
  fifo_1r1w_ctrl #(.DBITS(DBITS), .ABITS(ABITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DBITS-1:0] mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wr;
    if (bus.ram_re) bus.ram_rd <= mem[bus.ram_raddr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      tests++; if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0) begin fails++; $display("FAIL rst_ram_en: got we=%b re=%b want 0 0", bus.ram_we, bus.ram_re); end
      tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd0) begin fails++; $display("FAIL idle_state: got ov=%b cnt=%0d want 0 0", bus.out_valid, bus.count); end
      tests++; if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0) begin fails++; $display("FAIL idle_ram_en: got we=%b re=%b want 0 0", bus.ram_we, bus.ram_re); end
      tests++; if (bus.ram_waddr !== 3'd0 || bus.ram_raddr !== 3'd0) begin fails++; $display("FAIL idle_addr: got wa=%0d ra=%0d want 0 0", bus.ram_waddr, bus.ram_raddr); end
      tick();
    end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1'b1; #1;
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 3'd0) begin fails++; $display("FAIL single_we: got we=%b wa=%0d want 1 0", bus.ram_we, bus.ram_waddr); end
    tests++; if (bus.ram_wr !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wr: got %h want deadbeef", bus.ram_wr); end
    tick(); bus.in_valid = 1'b0; #1;
    tests++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 3'd0) begin fails++; $display("FAIL single_re: got re=%b ra=%0d want 1 0", bus.ram_re, bus.ram_raddr); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL single_cnt1: got %0d want 1", bus.count); end
    tick(); #1;
    tests++; if (bus.ram_re !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 5'd1) begin fails++; $display("FAIL single_inflight: got re=%b ov=%b cnt=%0d want 0 0 1", bus.ram_re, bus.out_valid, bus.count); end
    tick(); #1;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_out: got ov=%b d=%h want 1 deadbeef", bus.out_valid, bus.out_data); end
    tick(); #1;
    tests++; if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_empty: got cnt=%0d ov=%b want 0 0", bus.count, bus.out_valid); end
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    int v = 0;
    int cyc = 0;
    int exp = 1;
    bus.out_ready = 1'b0;
    while (v < 10 && cyc < 40) begin
      bus.in_valid = 1'b1; bus.in_data = v; #1;
      if (bus.in_ready) v++;
      tick(); cyc++;
    end
    tests++; if (cyc != 10) begin fails++; $display("FAIL fill_accept_cycles: got %0d want 10", cyc); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'd10; #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready: got %b want 0", bus.in_ready); end
      tick();
    end
    #1;
    tests++; if (bus.count !== 5'd10) begin fails++; $display("FAIL fill_count: got %0d want 10", bus.count); end
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0) begin fails++; $display("FAIL fill_head: got ov=%b d=%0d want 1 0", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1; #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_pop_same_cycle: got in_ready=%b want 0", bus.in_ready); end
    tick(); bus.out_ready = 1'b0; #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fill_after_pop: got in_ready=%b want 1", bus.in_ready); end
    tests++; if (bus.out_data !== 32'd1) begin fails++; $display("FAIL fill_next_head: got %0d want 1", bus.out_data); end
    tick(); bus.in_valid = 1'b0;
    cyc = 0;
    while (exp < 11 && cyc < 40) begin
      bus.out_ready = 1'b1; #1;
      if (bus.out_valid) begin
        tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL fill_order: got %0d want %0d", bus.out_data, exp); end
        exp++;
      end
      tick(); cyc++;
    end
    bus.out_ready = 1'b0;
    tests++; if (exp != 11) begin fails++; $display("FAIL fill_drain_timeout: got %0d popped want 10", exp - 1); end
    #1;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL fill_drained: got cnt=%0d want 0", bus.count); end
    tick();
  endtask

  task automatic test_stream();
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    bus.out_ready = 1'b1;
    while (rcv < 1000 && cyc < 1200) begin
      bus.in_valid = (sent < 1000); bus.in_data = sent; #1;
      if (bus.out_valid) begin
        tests++; if (bus.out_data !== rcv) begin fails++; $display("FAIL stream_data: got %0d want %0d", bus.out_data, rcv); end
        if (first < 0) first = cyc;
        last = cyc; rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick(); cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tests++; if (rcv != 1000) begin fails++; $display("FAIL stream_total: got %0d want 1000", rcv); end
    tests++; if (first != 3) begin fails++; $display("FAIL stream_latency: got %0d want 3", first); end
    tests++; if (last - first != 999) begin fails++; $display("FAIL stream_gaps: got span %0d want 999", last - first); end
    #1;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL stream_empty: got cnt=%0d want 0", bus.count); end
    tick();
  endtask

  task automatic test_random();
    logic [DBITS-1:0] q[$];
    int cyc = 0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1)); #1;
      tests++; if (int'(bus.count) != q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", bus.count, q.size()); end
      tests++; if (dut.os_cnt > 2'd2) begin fails++; $display("FAIL rand_os_cnt: got %0d want <=2", dut.os_cnt); end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL rand_underflow: got %h want nothing", bus.out_data); end
        else begin
          if (bus.out_data !== q[0]) begin fails++; $display("FAIL rand_data: got %h want %h", bus.out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (q.size() != 0 && cyc < 40) begin
      #1;
      if (bus.out_valid) begin
        tests++; if (bus.out_data !== q[0]) begin fails++; $display("FAIL rand_drain: got %h want %h", bus.out_data, q[0]); end
        void'(q.pop_front());
      end
      tick(); cyc++;
    end
    bus.out_ready = 1'b0;
    tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_drain_timeout: got %0d left want 0", q.size()); end
    #1;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rand_empty: got cnt=%0d want 0", bus.count); end
    tick();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h100 + i; #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mrst_push_ready: got %b want 1", bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #1;
    tests++; if (bus.count !== 5'd6 || bus.out_data !== 32'h100) begin fails++; $display("FAIL mrst_pre: got cnt=%0d d=%h want 6 100", bus.count, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0; rst = 1'b0; #1;
    tests++; if (bus.count !== 5'd5 || dut.rd_pend !== 1'b1) begin fails++; $display("FAIL mrst_setup: got cnt=%0d rd_pend=%b want 5 1", bus.count, dut.rd_pend); end
    tests++; if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL mrst_forced: got we=%b re=%b ir=%b want 0 0 0", bus.ram_we, bus.ram_re, bus.in_ready); end
    tick();
    rst = 1'b1; #1;
    tests++; if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL mrst_cleared: got cnt=%0d ov=%b want 0 0", bus.count, bus.out_valid); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mrst_stale: got ov=%b d=%h want 0", bus.out_valid, bus.out_data); end
    end
    tick();
    bus.in_valid = 1'b1; bus.in_data = 32'h1; #1;
    tests++; if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 3'd0) begin fails++; $display("FAIL mrst_push: got we=%b wa=%0d want 1 0", bus.ram_we, bus.ram_waddr); end
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid) begin
        tests++; if (bus.out_data !== 32'h1) begin fails++; $display("FAIL mrst_data: got %h want 1", bus.out_data); end
        n++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    tests++; if (n != 1) begin fails++; $display("FAIL mrst_alone: got %0d entries want 1", n); end
    #1;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL mrst_final: got cnt=%0d want 0", bus.count); end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_1r1w_ctrl.md
# fifo_1r1w_ctrl

Synchronous FIFO controller that owns both ports of an external `ram_generic_1r1w`-style memory: it generates write address/enable from a valid/ready push interface and read address/enable from a valid/ready pop interface. It absorbs the RAM's 1-cycle registered read latency with a 2-entry output stage, sustaining 1 push and 1 pop per cycle. It is used as the buffering element between pipeline stages, for example fetch queue and store buffer.

## Interface
- `DBITS`, default 32: data width; must match the RAM data width.
- `ABITS`, default 7: RAM address width; RAM depth `DEPTH = 1<<ABITS`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accepted when `in_valid & in_ready`.
- `in_data`  in  DBITS  push data.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  pop when `out_valid & out_ready`.
- `out_data`  out  DBITS  head entry data.
- `count`  out  ABITS+2  total entries held: RAM + in-flight read + output stage.
- `ram_waddr`  out  ABITS  RAM write address (= `wptr`).
- `ram_wr`  out  DBITS  RAM write data (= `in_data`).
- `ram_we`  out  1  RAM write enable.
- `ram_raddr`  out  ABITS  RAM read address (= `rptr`).
- `ram_re`  out  1  RAM read enable.
- `ram_rd`  in  DBITS  RAM registered read data, valid the cycle after `ram_re`.

## Operation
- State:
  - `wptr` and `rptr` are ABITS wide and wrap modulo DEPTH.
  - `ram_cnt` is ABITS+1 wide, range 0..DEPTH.
  - `rd_pend` is 1 bit: a read was issued last cycle.
  - The output stage is a 2-entry queue: `head` then `skid`, with `os_cnt` 0..2.
- Push:
  - `in_ready = rst & (ram_cnt != DEPTH)`.
  - `ram_we = in_valid & in_ready`.
  - On a push, `wptr++`.
- Read issue:
  - `ram_re = rst & (ram_cnt != 0) & (os_cnt + rd_pend - pop < 2)`, where `pop = out_valid & out_ready`.
  - On a read issue, `rptr++`.
- `ram_cnt` update: next value is `ram_cnt + ram_we - ram_re`. A push and a read issue in the same cycle leave it unchanged.
- Return: when `rd_pend=1`, `ram_rd` is enqueued into the output stage the same cycle. This happens after a pop of `head`, if any, in that cycle.
- Output stage:
  - `out_valid = (os_cnt != 0)` and `out_data = head`.
  - On a pop, `skid` moves to `head`.
  - Returned data fills the first free slot.
  - `os_cnt` never exceeds 2. The read-issue rule guarantees this; exceeding it is an assertion failure.
- Same-address hazard: a read is issued only when the registered `ram_cnt != 0`. Therefore `rptr != wptr` or the RAM is full with `in_ready=0`. Read and write never target the same address in one cycle.
- `count = ram_cnt + rd_pend + os_cnt`. Maximum is DEPTH+2.
- Ordering is strict FIFO. Data is never dropped or duplicated.
- Reset (`rst=0` at a clock edge):
  - `wptr`, `rptr`, `ram_cnt`, `rd_pend` and `os_cnt` clear to 0.
  - Any in-flight read is discarded.
  - `head` and `skid` contents are don't-care.
  - While `rst=0`, `ram_we`, `ram_re` and `in_ready` are forced 0.

## Timing
- Reset values:
  - `in_ready=0` while in reset, and 1 in the first cycle after reset.
  - `out_valid=0`, `count=0`, `ram_we=0`, `ram_re=0`.
  - `ram_waddr=0`, `ram_raddr=0`.
- Latency into an empty FIFO:
  - Push accepted in cycle t.
  - `ram_re` in t+1.
  - `ram_rd` valid and enqueued in t+2.
  - `out_valid=1` in t+3.
- Throughput: with continuous push and `out_ready=1`, one entry leaves per cycle after the initial 3-cycle fill.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`: a pop does not free space in the same cycle.
- `ram_re` depends combinationally on `out_ready`.
- A RAM write completes at the edge of its push cycle. A read issued in the following cycle sees the new data.

## Test plan
- Reset then idle:
  - Apply `rst=0` for 2 cycles, then release.
  - Required: `out_valid=0`, `count=0` and `in_ready=1`; no `ram_we`/`ram_re` pulses.
- Single entry:
  - Push `0xDEADBEEF` in cycle 5 with `out_ready=1`.
  - Required: `ram_we`@5 with addr 0; `ram_re`@6 with addr 0; `out_valid`@8 with data `0xDEADBEEF`; `count` returns to 0 at cycle 9.
- Fill to full (ABITS=3):
  - Push 0..11 with `out_ready=0`.
  - Required: the first 10 are accepted (8 in RAM, 2 in the output stage) and `count=10`.
  - Required: `in_ready=0` on the 11th. The 11th value is held on `in_data` and is accepted one cycle after the first pop.
  - Required: pops return 0,1,2,...
- Streaming with wrap:
  - Push 0..999 back-to-back with `out_ready=1`.
  - Required: 1000 values out in order, one per cycle after the fill; pointers wrap without gaps.
- Random backpressure:
  - Drive `in_valid` and `out_ready` at 50% random against a scoreboard.
  - Required: in-order match, `count` equals the scoreboard depth every cycle, and `os_cnt<=2` throughout.
- Reset mid-operation:
  - Assert `rst=0` for one cycle while `rd_pend=1` and `count=5`.
  - Required: the next cycle shows `count=0` and `out_valid=0`; the returning `ram_rd` is ignored; a subsequent push of `0x1` emerges alone.
